// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bundle: pipeline control, redirects, instruction-ROM bus and IF/ID outputs.
// master = fetch stage side; slave = surrounding pipeline, ROM and test environment.
// Ports: stall_if/stall_id/flush/new_pc/branch_flag/branch_target (control in),
//        rom_ce/rom_addr out, rom_inst in, id_pc/id_inst/id_valid/misalign out.
interface if_fetch_stage_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
);
  logic              stall_if;
  logic              stall_id;
  logic              flush;
  logic [ADDR_W-1:0] new_pc;
  logic              branch_flag;
  logic [ADDR_W-1:0] branch_target;
  logic              rom_ce;
  logic [ADDR_W-1:0] rom_addr;
  logic [INST_W-1:0] rom_inst;
  logic [ADDR_W-1:0] id_pc;
  logic [INST_W-1:0] id_inst;
  logic              id_valid;
  logic              misalign;

  modport master (
    input  stall_if, stall_id, flush, new_pc, branch_flag, branch_target, rom_inst,
    output rom_ce, rom_addr, id_pc, id_inst, id_valid, misalign
  );

  modport slave (
    output stall_if, stall_id, flush, new_pc, branch_flag, branch_target, rom_inst,
    input  rom_ce, rom_addr, id_pc, id_inst, id_valid, misalign
  );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction fetch: owns the PC, drives the combinational ROM, registers the result into IF/ID.
// Latency: instruction at rom_addr appears on id_* one cycle later; first valid 2 cycles after reset.
// Backpressure: stall_id holds IF/ID and PC; stall_if holds PC and inserts bubbles; flush overrides both.
// Ports: clk, rst (async active-low), bus (if_fetch_stage_if.master).
// Option: define BRANCH_DELAY_SLOT_EN to keep the delay-slot instruction on a taken branch;
//         otherwise it is squashed into a bubble.
module if_fetch_stage #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  if_fetch_stage_if.master bus
);

  typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
    logic              valid;
  } ifid_t;

  localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(3));

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              misalign_q, misalign_d;
  ifid_t             ifid_q, ifid_d;

  logic stall_eff;
  logic take_branch;
  logic squash_slot;

  // stall_id backs up into fetch as well, so the PC must hold under either stall.
  assign stall_eff   = bus.stall_if | bus.stall_id;
  assign take_branch = bus.branch_flag & ~stall_eff & ~bus.flush;

`ifdef BRANCH_DELAY_SLOT_EN
  assign squash_slot = 1'b0;
`else
  assign squash_slot = take_branch;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
      ifid_q     <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
      ifid_q     <= ifid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    misalign_d = misalign_q;
    ifid_d     = ifid_q;

    case (state_q)
      BOOT:      state_d = RUN;
      RUN, HOLD: state_d = stall_eff ? HOLD : RUN;
      default:   state_d = BOOT;
    endcase

    // PC only moves once the ROM is enabled; the BOOT cycle never redirects.
    if (state_q != BOOT) begin
      if (bus.flush) begin
        pc_d       = bus.new_pc & ALIGN_MASK;
        // A flush is the only clear; a misaligned handler target re-arms the flag.
        misalign_d = |bus.new_pc[1:0];
      end else if (take_branch) begin
        pc_d = bus.branch_target & ALIGN_MASK;
        if (|bus.branch_target[1:0]) begin
          misalign_d = 1'b1;
        end
      end else if (!stall_eff) begin
        pc_d = pc_q + PC_STEP;
      end
    end

    if (bus.flush) begin
      ifid_d = '{pc: pc_q, inst: '0, valid: 1'b0};
    end else if (bus.stall_id) begin
      ifid_d = ifid_q;
    end else if (bus.stall_if || state_q == BOOT || squash_slot) begin
      ifid_d = '{pc: pc_q, inst: '0, valid: 1'b0};
    end else begin
      ifid_d = '{pc: pc_q, inst: bus.rom_inst, valid: 1'b1};
    end
  end

  assign bus.rom_ce   = (state_q != BOOT);
  assign bus.rom_addr = pc_q;
  assign bus.id_pc    = ifid_q.pc;
  assign bus.id_inst  = ifid_q.inst;
  assign bus.id_valid = ifid_q.valid;
  assign bus.misalign = misalign_q;

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch front end sitting directly upstream of the instruction ROM.
- Owns the PC and drives the ROM address and chip-enable.
- Captures the combinationally returned instruction into the IF/ID pipeline register for the decode stage.
- Handles pipeline stalls, branch redirect, exception flush, boot sequencing and target-alignment checking.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; word-aligned.
ADDR_W, 32, PC / ROM address width.
INST_W, 32, instruction width.

Ports:
clk  in  1  system clock, rising-edge.
rst  in  1  asynchronous, active-low reset.
stall_if  in  1  hold PC (fetch stalled).
stall_id  in  1  hold IF/ID register (decode stalled); implies stall_if.
flush  in  1  exception flush; redirect to new_pc.
new_pc  in  ADDR_W  exception/handler target.
branch_flag  in  1  branch taken, resolved in ID.
branch_target  in  ADDR_W  branch destination.
rom_ce  out  1  ROM enable.
rom_addr  out  ADDR_W  ROM byte address (= pc); ROM indexes addr[..:2].
rom_inst  in  INST_W  instruction returned same cycle (combinational ROM).
id_pc  out  ADDR_W  IF/ID registered PC.
id_inst  out  INST_W  IF/ID registered instruction.
id_valid  out  1  IF/ID holds a real instruction.
misalign  out  1  sticky: a redirect target had bits [1:0] != 0.

Behaviour:
- Reset (rst=0, asynchronous): pc=RESET_PC, rom_ce=0, id_pc=0, id_inst=0, id_valid=0, misalign=0, state=BOOT.
- FSM states:
  - BOOT: rom_ce=0, pc held. Next cycle goes to RUN.
  - RUN: rom_ce=1, normal fetch.
  - HOLD: rom_ce=1, pc held. Entered when the effective stall_if=1; returns to RUN on the first cycle with stall_if=0, with no lost or duplicated fetch.
- Effective stall: stall_if_eff = stall_if | stall_id.
- PC update in RUN/HOLD, priority high to low:
  - flush -> new_pc.
  - branch_flag & !stall_if_eff -> branch_target.
  - stall_if_eff -> hold.
  - else pc+4, wrapping modulo 2^ADDR_W (0xFFFF_FFFC -> 0x0000_0000).
- branch_flag is ignored whenever stall_if_eff=1.
- Redirect alignment:
  - Redirect targets are loaded with bits [1:0] forced to 0.
  - If the raw target had [1:0] != 0, misalign is set the next cycle and stays set until a flush cycle clears it.
  - A flush whose new_pc is itself misaligned sets misalign instead of clearing it.
- IF/ID register, priority high to low:
  - flush: id_valid=0, id_inst=0 (overrides stall_id).
  - stall_id: hold all three fields.
  - stall_if (without stall_id) or state BOOT: bubble, i.e. id_valid=0, id_inst=0, id_pc=pc.
  - else: id_pc=pc, id_inst=rom_inst, id_valid=1.
- Latency: instruction at pc appears on id_* one cycle after rom_addr=pc with no stall.
- First valid id_* is 2 cycles after reset release: BOOT cycle, then fetch of RESET_PC.
- Simultaneous flush+branch_flag: flush wins; the branch is discarded.
- Reset mid-stall or mid-redirect: everything returns to reset values; no redirect is retained.

Optional Feature:
- Macro: BRANCH_DELAY_SLOT_EN.
- Defined: on a taken branch_flag cycle the instruction currently fetched (pc, the delay slot) is captured normally into IF/ID (id_valid=1). This is MIPS delay-slot semantics.
- Undefined: on a taken branch cycle IF/ID loads a bubble (id_valid=0, id_inst=0). The delay-slot instruction is squashed.
- PC update is identical in both builds.

Test Plan:
- Release reset, no stalls -> rom_ce 0 for 1 cycle. rom_addr then reads 0x0, 0x4, 0x8. id_valid first 1 two cycles after release, with id_pc=0x0 and id_inst=mem[0].
- stall_if=1 for 3 cycles at pc=0x10, stall_id=0 -> rom_addr stays 0x10. id_valid=0 for 3 cycles. On release, id_pc=0x10 is captured exactly once.
- stall_id=1 for 2 cycles -> id_pc/id_inst/id_valid unchanged and pc held. flush during stall_id -> id_valid=0 next cycle and pc=new_pc.
- branch_flag=1, branch_target=0x100 at pc=0x20 -> next rom_addr=0x100. Next cycle id_pc=0x20: valid with BRANCH_DELAY_SLOT_EN, id_valid=0 without it.
- branch_target=0x102 -> pc=0x100 and misalign=1 next cycle. Stays 1 until flush with new_pc=0x200 clears it.
- flush and branch_flag in the same cycle (new_pc=0x180, target=0x40) -> pc=0x180. pc=0xFFFF_FFFC with no stall -> next pc=0x0.
